// File: rtl/ad_pkg.sv
// Shared definitions for the AD acquisition sequencer: default widths and
// the capture FSM state encoding.
package ad_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 10;
  localparam int DIV_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } ad_state_e;

endpackage

// File: rtl/ad_trig_det.sv
// Trigger detector: remembers the previous strobed sample and flags a rising
// or falling crossing of the threshold on the current strobe.
module ad_trig_det #(
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_strobe,
  input  logic [DW-1:0] i_sample,
  input  logic [DW-1:0] i_level,
  input  logic          i_edge,
  output logic          o_hit
);

  logic [DW-1:0] r_prev;
  logic          r_prev_valid;
  logic          w_rise;
  logic          w_fall;

  // Clearing invalidates the history so the first sample of a capture can
  // never form an edge with a sample left over from an earlier record.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
    end else if (i_strobe) begin
      r_prev       <= i_sample;
      r_prev_valid <= 1'b1;
    end
  end

  assign w_rise = (r_prev < i_level) && (i_sample >= i_level);
  assign w_fall = (r_prev >= i_level) && (i_sample < i_level);
  assign o_hit  = i_strobe && r_prev_valid && (i_edge ? w_fall : w_rise);

endmodule

// File: rtl/ad_capture_ctrl.sv
// Acquisition sequencer: divides clk into a sample strobe, writes a
// pre-trigger + post-trigger record into a circular buffer, reports its base.
module ad_capture_ctrl
  import ad_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DW-1:0]    i_ad_data,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_trig_en,
  input  logic             i_trig_edge,
  input  logic [DW-1:0]    i_trig_level,
  input  logic [DIV_W-1:0] i_div,
  input  logic [AW-1:0]    i_pre_len,
  output logic             o_wr_en,
  output logic [AW-1:0]    o_wr_addr,
  output logic [DW-1:0]    o_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [AW-1:0]    o_rec_base,
  output logic [2:0]       o_state
);

  ad_state_e        r_state, w_next;
  logic [DIV_W-1:0] r_div, r_div_cnt;
  logic [AW-1:0]    r_pre_len, r_ptr, r_trig_addr, r_wr_addr, r_rec_base;
  logic [DW-1:0]    r_level, r_wr_data;
  logic             r_trig_en, r_trig_edge, r_wr_en, r_done;
  logic [AW:0]      r_cnt;
  logic [AW:0]      w_post_total;
  logic             w_busy, w_start_ok, w_post_full, w_strobe, w_hit, w_trigger;

  assign w_busy       = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
  assign w_start_ok   = i_start && !i_abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_post_total = {1'b1, {AW{1'b0}}} - {1'b0, r_pre_len};
  // Once every post sample is captured, strobes stop while the last write drains.
  assign w_post_full  = (r_state == ST_POST) && (r_cnt == w_post_total);
  assign w_strobe     = w_busy && (r_div_cnt == r_div) && !w_post_full;
  assign w_trigger    = (r_state == ST_WAIT) && w_strobe && (!r_trig_en || w_hit);

  ad_trig_det #(.DW(DW)) u_trig_det (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_start_ok || i_abort),
    .i_strobe (w_strobe),
    .i_sample (i_ad_data),
    .i_level  (r_level),
    .i_edge   (r_trig_edge),
    .o_hit    (w_hit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (w_start_ok) w_next = (i_pre_len == '0) ? ST_WAIT : ST_PRE;
        ST_PRE:  if (w_strobe && ((r_cnt + 1'b1) == {1'b0, r_pre_len})) w_next = ST_WAIT;
        ST_WAIT: if (w_trigger) w_next = ST_POST;
        ST_POST: if (w_post_full && r_wr_en) w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_pre_len   <= '0;
      r_ptr       <= '0;
      r_trig_addr <= '0;
      r_wr_addr   <= '0;
      r_rec_base  <= '0;
      r_level     <= '0;
      r_wr_data   <= '0;
      r_trig_en   <= 1'b0;
      r_trig_edge <= 1'b0;
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_wr_en <= w_strobe && !i_abort;
      if (w_busy) r_div_cnt <= (r_div_cnt == r_div) ? '0 : r_div_cnt + 1'b1;
      if (w_strobe) begin
        r_wr_data <= i_ad_data;
        r_wr_addr <= r_ptr;
        r_ptr     <= r_ptr + 1'b1;
      end
      // PRE counts pre samples; the trigger sample is the first post sample.
      if (w_trigger) begin
        r_cnt       <= {{AW{1'b0}}, 1'b1};
        r_trig_addr <= r_ptr;
      end else if (w_strobe && (r_state != ST_WAIT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_state == ST_POST) && (w_next == ST_DONE)) begin
        r_rec_base <= r_trig_addr - r_pre_len;
        r_done     <= 1'b1;
      end
      if (i_abort) r_done <= 1'b0;
      if (w_start_ok) begin
        r_trig_en   <= i_trig_en;
        r_trig_edge <= i_trig_edge;
        r_level     <= i_trig_level;
        r_div       <= i_div;
        r_pre_len   <= i_pre_len;
        r_done      <= 1'b0;
        r_ptr       <= '0;
        r_wr_addr   <= '0;
        r_div_cnt   <= '0;
        r_cnt       <= '0;
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = w_busy;
  assign o_done     = r_done;
  assign o_rec_base = r_rec_base;
  assign o_state    = r_state;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// Self-checking bench for ad_capture_ctrl with a 16-entry buffer: expected
// buffer writes are queued as samples are driven and popped as writes appear.
module tb_ad_capture_ctrl;
  import ad_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    i_ad_data;
  logic             i_start, i_abort, i_trig_en, i_trig_edge;
  logic [DW-1:0]    i_trig_level;
  logic [DIV_W-1:0] i_div;
  logic [AW-1:0]    i_pre_len;
  logic             o_wr_en, o_busy, o_done;
  logic [AW-1:0]    o_wr_addr, o_rec_base;
  logic [DW-1:0]    o_wr_data;
  logic [2:0]       o_state;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    stim[$];
  logic [AW+DW-1:0] mon_e;
  int               n_chk = 0;
  int               n_pass = 0;
  bit               mon_en = 1'b0;

  ad_capture_ctrl #(.DW(DW), .AW(AW), .DIV_W(DIV_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ad_data    (i_ad_data),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_trig_en    (i_trig_en),
    .i_trig_edge  (i_trig_edge),
    .i_trig_level (i_trig_level),
    .i_div        (i_div),
    .i_pre_len    (i_pre_len),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rec_base   (o_rec_base),
    .o_state      (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every buffer write must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en && o_wr_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%02h, expected no write", o_wr_addr, o_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_wr_addr, o_wr_data} !== mon_e)
          $display("FAIL write_data: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   o_wr_addr, o_wr_data, mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
        else n_pass++;
      end
    end
  end

  // driver tasks
  task automatic set_cfg(input bit ten, input bit edg, input logic [DW-1:0] lvl,
                         input int dv, input int pl);
    i_trig_en    = ten;
    i_trig_edge  = edg;
    i_trig_level = lvl;
    i_div        = DIV_W'(dv);
    i_pre_len    = AW'(pl);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
  endtask

  // div=0 streaming: sample i is captured at the edge after it is driven and
  // written to address i mod DEPTH one cycle later.
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_start   = 1'b0;
      i_ad_data = stim[i];
      exp_q.push_back({AW'(i), stim[i]});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_ad_data = '0; i_start = 1'b0; i_abort = 1'b0;
    set_cfg(0, 0, 8'h00, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_rec_base, o_state} !== '0)
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%02h busy=%b done=%b base=%0d st=%0d, expected all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_rec_base, o_state);
    else n_pass++;
  endtask

  task automatic test_ramp_free_run();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(DW'(i));
    set_cfg(0, 0, 8'h00, 0, 4);
    mon_en = 1'b1;
    pulse_start();
    stream(16);
    @(negedge clk);
    n_chk++;
    if ({o_busy, o_done} !== 2'b10) $display("FAIL ramp_last_write: got busy=%b done=%b, expected busy=1 done=0", o_busy, o_done);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({o_busy, o_done, o_wr_en, o_rec_base, o_state} !== {3'b010, 4'd0, 3'(ST_DONE)})
      $display("FAIL ramp_done: got busy=%b done=%b en=%b base=%0d st=%0d, expected busy=0 done=1 en=0 base=0 st=%0d",
               o_busy, o_done, o_wr_en, o_rec_base, o_state, ST_DONE);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL ramp_count: got %0d writes missing, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_divided_strobe();
    int bad_wr, bad_busy;
    logic [DW-1:0] d;
    bit exp_wr;
    bad_wr = 0; bad_busy = 0;
    set_cfg(0, 0, 8'h00, 3, 0);
    pulse_start();
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      i_start   = 1'b0;
      d         = DW'($urandom_range(0, 255));
      i_ad_data = d;
      if ((c % 4 == 0) && (c <= 64)) exp_q.push_back({AW'(c / 4 - 1), d});
      exp_wr = (c >= 5) && (c <= 65) && ((c - 5) % 4 == 0);
      if (o_wr_en !== exp_wr) bad_wr++;
      if (o_busy !== (c <= 65)) bad_busy++;
    end
    n_chk++;
    if (bad_wr != 0) $display("FAIL div_strobe_timing: got %0d cycles with wrong wr_en, expected 0", bad_wr);
    else n_pass++;
    n_chk++;
    if (bad_busy != 0) $display("FAIL div_busy: got %0d cycles with wrong busy, expected 0", bad_busy);
    else n_pass++;
    n_chk++;
    if ({o_done, o_rec_base} !== {1'b1, 4'd0}) $display("FAIL div_done: got done=%b base=%0d, expected done=1 base=0", o_done, o_rec_base);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL div_count: got %0d writes missing, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_rising_trigger();
    stim.delete();
    for (int i = 0; i < 30; i++) stim.push_back(8'h10);
    for (int i = 0; i < 12; i++) stim.push_back(8'h90);
    set_cfg(1, 0, 8'h80, 0, 4);
    pulse_start();
    stream(42);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({o_done, o_busy, o_rec_base} !== {2'b10, 4'd10})
      $display("FAIL rise_record: got done=%b busy=%b base=%0d, expected done=1 busy=0 base=10", o_done, o_busy, o_rec_base);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL rise_count: got %0d writes missing, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_falling_first_sample();
    stim.delete();
    stim.push_back(8'h10); stim.push_back(8'h10); stim.push_back(8'h90);
    stim.push_back(8'h90); stim.push_back(8'h10);
    for (int i = 0; i < 15; i++) stim.push_back(DW'($urandom_range(0, 255)));
    i_ad_data = 8'h90;
    repeat (2) @(negedge clk);
    set_cfg(1, 1, 8'h80, 0, 0);
    pulse_start();
    stream(20);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({o_done, o_rec_base} !== {1'b1, 4'd4})
      $display("FAIL fall_record: got done=%b base=%0d, expected done=1 base=4", o_done, o_rec_base);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL fall_count: got %0d writes missing, expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(DW'(8'h20 + i));
    set_cfg(0, 0, 8'h00, 0, 0);
    pulse_start();
    stream(6);
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_wr_en, o_busy, o_done, o_state} !== {3'b000, 3'(ST_IDLE)})
      $display("FAIL abort_post: got en=%b busy=%b done=%b st=%0d, expected all 0", o_wr_en, o_busy, o_done, o_state);
    else n_pass++;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL abort_pending: got %0d writes missing, expected 0", exp_q.size());
    else n_pass++;
    i_start = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_busy, o_state} !== {1'b0, 3'(ST_IDLE)})
      $display("FAIL abort_wins_idle: got busy=%b st=%0d, expected busy=0 st=%0d", o_busy, o_state, ST_IDLE);
    else n_pass++;
    // re-arm one cycle after the abort
    i_abort = 1'b0;
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(8'h00);
    for (int i = 0; i < 14; i++) stim.push_back(8'h90);
    set_cfg(1, 0, 8'h80, 0, 2);
    stream(19);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({o_done, o_rec_base} !== {1'b1, 4'd3})
      $display("FAIL rearm_record: got done=%b base=%0d, expected done=1 base=3", o_done, o_rec_base);
    else n_pass++;
    i_abort = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    i_start = 1'b0;
    n_chk++;
    if ({o_done, o_busy, o_state, o_rec_base} !== {2'b00, 3'(ST_IDLE), 4'd3})
      $display("FAIL abort_wins_done: got done=%b busy=%b st=%0d base=%0d, expected done=0 busy=0 st=0 base=3",
               o_done, o_busy, o_state, o_rec_base);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int n_wr;
    mon_en    = 1'b0;
    i_ad_data = 8'h55;
    set_cfg(1, 0, 8'hFF, 1, 2);
    pulse_start();
    repeat (10) @(negedge clk) i_start = 1'b0;
    set_cfg(0, 0, 8'h00, 0, 5);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n_wr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_wr_en === 1'b1) n_wr++;
    end
    n_chk++;
    if (n_wr != 10) $display("FAIL busy_start_ignored: got %0d writes in 20 cycles, expected 10", n_wr);
    else n_pass++;
    n_chk++;
    if (o_state !== 3'(ST_WAIT)) $display("FAIL busy_start_state: got st=%0d, expected %0d", o_state, ST_WAIT);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_rec_base, o_state} !== '0)
      $display("FAIL reset_mid_wait: got en=%b addr=%0d data=%02h busy=%b done=%b base=%0d st=%0d, expected all 0",
               o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_rec_base, o_state);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ramp_free_run();
    test_divided_strobe();
    test_rising_trigger();
    test_falling_first_sample();
    test_abort();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
